// File: rtl/eth_10g_gen_pkg.sv
// eth_10g_pkg: register map, control bits, CRC constants and FSM states for the 10G packet generator
package eth_10g_pkg;
  localparam logic [2:0] REG_NUM = 3'd0, REG_WORDS = 3'd1, REG_PKTS = 3'd2, REG_BYTES_LO = 3'd3,
                         REG_BYTES_HI = 3'd4, REG_GAP = 3'd5, REG_CTRL = 3'd7;
  localparam int CTRL_START = 0, CTRL_STOP = 1, CTRL_DONE = 2, CTRL_BUSY = 3;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7, CRC32_INIT = 32'hFFFFFFFF;
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction
  // LSB-first shifting needs the bit-reversed polynomial
  localparam logic [31:0] CRC32_POLY_R = reflect32(CRC32_POLY);
  typedef enum logic [1:0] {IDLE, DATA, CRC, GAP} state_t;
endpackage

// File: rtl/eth_10g_gen_if.sv
// eth_10g_gen_if: Avalon-MM register port plus Avalon-ST transmit stream of the generator
interface eth_10g_gen_if;
  logic [2:0]  address;
  logic        write, read;
  logic [31:0] writedata, readdata;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_error, tx_ready;
  logic [2:0]  tx_empty;
  modport master (output address, write, read, writedata, tx_ready,
                  input readdata, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, tx_error);
  modport slave  (input address, write, read, writedata, tx_ready,
                  output readdata, tx_data, tx_valid, tx_sop, tx_eop, tx_empty, tx_error);
endinterface

// File: rtl/eth_10g_gen_crc32_d64.sv
// crc32_d64: next Ethernet CRC state after one 64-bit word, first byte in [63:56], bits LSB-first
module crc32_d64
  import eth_10g_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [63:0] data,
  output logic [31:0] crc_next
);
  logic [31:0] c;
  always_comb begin
    c = crc;
    for (int i = 0; i < 64; i++)
      c = {1'b0, c[31:1]} ^ ((c[0] ^ data[56 - 8*(i/8) + i%8]) ? CRC32_POLY_R : 32'h0);
    crc_next = c;
  end
endmodule

// File: rtl/eth_10g_gen.sv
// eth_10g_gen: register-programmed Avalon-ST frame generator appending an Ethernet FCS
module eth_10g_gen
  import eth_10g_pkg::*;
#(
  parameter int DEFAULT_WORDS = 8,
  parameter int DEFAULT_GAP   = 2
) (
  input logic         clk,
  input logic         reset_n,
  eth_10g_gen_if.slave bus
);
  state_t      state, nxt;
  logic [31:0] num_pkt, sh_num, pkts, pkts_inc, crc, crc_nxt, crcv, ctrl_rd;
  logic [63:0] bytes;
  logic [10:0] words_r, sh_words, n_words, k;
  logic [7:0]  gap_r, sh_gap, gcnt;
  logic        ctrl0, ctrl0_q, stop_pend, done, wr_ctrl, start_go, fire, last_pkt, finish;

  crc32_d64 u_crc (.crc(crc), .data(bus.tx_data), .crc_next(crc_nxt));

  assign wr_ctrl  = bus.write && bus.address == REG_CTRL;
  assign start_go = ctrl0 && !ctrl0_q && state == IDLE;
  assign n_words  = sh_words == 11'd0 ? 11'd1 : sh_words;
  assign fire     = bus.tx_valid && bus.tx_ready;
  assign pkts_inc = pkts + 32'd1;
  assign last_pkt = sh_num != 32'd0 && pkts_inc == sh_num;
  assign finish   = last_pkt || stop_pend;
  assign crcv     = ~crc;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = start_go ? DATA : IDLE;
      DATA: nxt = (fire && k == n_words - 11'd1) ? CRC : DATA;
      CRC:  nxt = !fire ? CRC : finish ? IDLE : sh_gap == 8'd0 ? DATA : GAP;
      GAP:  nxt = stop_pend ? IDLE : gcnt == 8'd1 ? DATA : GAP;
    endcase
    bus.tx_valid = state == DATA || state == CRC;
    bus.tx_sop   = state == DATA && k == 11'd0;
    bus.tx_eop   = state == CRC;
    bus.tx_empty = state == CRC ? 3'd4 : 3'd0;
    bus.tx_error = 1'b0;
    // FCS goes out low CRC byte first, so it lands byte-swapped in the big-endian beat
    bus.tx_data  = state == DATA ? {pkts, 21'd0, k} :
                   state == CRC  ? {crcv[7:0], crcv[15:8], crcv[23:16], crcv[31:24], 32'h0} : 64'h0;
    ctrl_rd = 32'h0;
    ctrl_rd[CTRL_DONE] = done;
    ctrl_rd[CTRL_BUSY] = state != IDLE;
    bus.readdata = !bus.read                      ? 32'h0 :
                   bus.address == REG_NUM         ? num_pkt :
                   bus.address == REG_WORDS       ? {21'd0, words_r} :
                   bus.address == REG_PKTS        ? pkts :
                   bus.address == REG_BYTES_LO    ? bytes[31:0] :
                   bus.address == REG_BYTES_HI    ? bytes[63:32] :
                   bus.address == REG_GAP         ? {24'd0, gap_r} :
                   bus.address == REG_CTRL        ? ctrl_rd : 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      num_pkt <= '0; words_r <= 11'(DEFAULT_WORDS); gap_r <= 8'(DEFAULT_GAP);
      sh_num <= '0; sh_words <= '0; sh_gap <= '0;
      pkts <= '0; bytes <= '0; k <= '0; gcnt <= '0; crc <= CRC32_INIT;
      ctrl0 <= 1'b0; ctrl0_q <= 1'b0; stop_pend <= 1'b0; done <= 1'b0;
    end else begin
      state <= nxt;
      if (bus.write && bus.address == REG_NUM) num_pkt <= bus.writedata;
      if (bus.write && bus.address == REG_WORDS) words_r <= bus.writedata[10:0];
      if (bus.write && bus.address == REG_GAP) gap_r <= bus.writedata[7:0];
      if (wr_ctrl) ctrl0 <= bus.writedata[CTRL_START];
      ctrl0_q <= ctrl0;
      stop_pend <= (wr_ctrl && bus.writedata[CTRL_STOP]) ? 1'b1 :
                   (state != IDLE && nxt == IDLE) ? 1'b0 : stop_pend;
      if (start_go) begin
        sh_num <= num_pkt; sh_words <= words_r; sh_gap <= gap_r;
        pkts <= '0; bytes <= '0; done <= 1'b0; k <= '0; crc <= CRC32_INIT;
      end
      if (state == DATA && fire) begin
        crc <= crc_nxt;
        k <= k + 11'd1;
      end
      if (state == CRC && fire) begin
        pkts <= pkts_inc;
        bytes <= bytes + 64'({n_words, 3'b100});
        crc <= CRC32_INIT;
        k <= '0;
        gcnt <= sh_gap;
        if (last_pkt) done <= 1'b1;
      end
      if (state == GAP) gcnt <= gcnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_eth_10g_gen.sv
// tb_eth_10g_gen: scoreboard bench for the 10G frame generator with an FCS-checking loopback monitor
module tb_eth_10g_gen;
  logic clk = 1'b0, reset_n = 1'b0, rnd_rdy = 1'b0;
  eth_10g_gen_if bus();
  eth_10g_gen #(.DEFAULT_WORDS(8), .DEFAULT_GAP(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int sop_cnt, frames, rx_ok, rx_err, idle;
  bit seen_eop, hold_v;
  logic [68:0] sb[$];
  logic [68:0] held, cur;
  byte unsigned pay[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input byte unsigned b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= 32'(b[i]);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] fcs_word(input logic [31:0] c);
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  task automatic push_frames(input int n, input int w, input int s0);
    int wv;
    byte unsigned b[$];
    logic [63:0] d;
    wv = w == 0 ? 1 : w;
    for (int p = 0; p < n; p++) begin
      b.delete();
      for (int k = 0; k < wv; k++) begin
        d = {32'(s0 + p), 32'(k)};
        sb.push_back({d, k == 0, 1'b0, 3'd0});
        for (int i = 7; i >= 0; i--) b.push_back(d[8*i +: 8]);
      end
      sb.push_back({fcs_word(crc_ref(b)), 32'h0, 1'b0, 1'b1, 3'd4});
    end
  endtask

  always begin
    @(posedge clk); #1;
    bus.tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (reset_n) begin
    cur = {bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_empty};
    if (hold_v) check("stall_hold", cur, held);
    hold_v = bus.tx_valid && !bus.tx_ready;
    held = cur;
    if (!bus.tx_valid) idle++;
    else if (bus.tx_ready) begin
      if (bus.tx_sop) begin
        sop_cnt++;
        pay.delete();
        if (seen_eop) check("gap", idle, 2);
      end
      check("sb_avail", sb.size() != 0, 1);
      if (sb.size() != 0) check("beat", cur, sb.pop_front());
      if (!bus.tx_eop) for (int i = 7; i >= 0; i--) pay.push_back(bus.tx_data[8*i +: 8]);
      else begin
        if (bus.tx_data[63:32] == fcs_word(crc_ref(pay))) rx_ok++; else rx_err++;
        frames++;
        seen_eop = 1;
        idle = 0;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.read = 1'b1;
    #1 d = bus.readdata;
    bus.read = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic start();
    wr(3'd7, 32'h1);
    wr(3'd7, 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    logic [31:0] d;
    do begin rd(3'd7, d); n++; end while (d[3] && n < 5000);
    check("idle_in_time", n < 5000, 1);
  endtask

  task automatic wait_sop(input int n);
    int c = 0;
    while (sop_cnt < n && c < 2000) begin @(posedge clk); c++; end
    #1 check("sop_in_time", sop_cnt >= n, 1);
  endtask

  task automatic begin_test();
    sop_cnt = 0; frames = 0; rx_ok = 0; rx_err = 0; idle = 0; seen_eop = 0; hold_v = 0;
    sb.delete();
  endtask

  task automatic end_test(input int n);
    check("frames", frames, n);
    check("rx_ok", rx_ok, n);
    check("rx_err", rx_err, 0);
    check("sb_left", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    byte unsigned kat[$];
    bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;
    begin_test();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_tx", {bus.tx_valid, bus.tx_sop, bus.tx_eop, bus.tx_empty, bus.tx_error, bus.tx_data}, 0);
    check("rst_rdata", bus.readdata, 0);
    rd_chk(3'd0, 0, "rst_num");
    rd_chk(3'd1, 8, "rst_words");
    rd_chk(3'd2, 0, "rst_pkts");
    rd_chk(3'd5, 2, "rst_gap");
    rd_chk(3'd6, 0, "rst_reg6");
    rd_chk(3'd7, 0, "rst_ctrl");
    kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_kat", crc_ref(kat), 32'hCBF43926);

    begin_test();
    wr(3'd0, 3);
    push_frames(3, 8, 0);
    start();
    wait_idle();
    rd_chk(3'd2, 3, "t1_pkts");
    rd_chk(3'd3, 204, "t1_bytes_lo");
    rd_chk(3'd4, 0, "t1_bytes_hi");
    rd_chk(3'd7, 4, "t1_ctrl");
    end_test(3);

    begin_test();
    rnd_rdy = 1'b1;
    wr(3'd0, 5);
    wr(3'd1, 1);
    push_frames(5, 1, 0);
    start();
    wait_idle();
    rnd_rdy = 1'b0;
    rd_chk(3'd2, 5, "t2_pkts");
    rd_chk(3'd3, 60, "t2_bytes");
    end_test(5);

    begin_test();
    wr(3'd0, 0);
    wr(3'd1, 8);
    push_frames(3, 8, 0);
    start();
    wait_sop(3);
    wr(3'd7, 32'h2);
    wait_idle();
    rd_chk(3'd2, 3, "t3_pkts");
    rd_chk(3'd7, 0, "t3_ctrl");
    end_test(3);

    begin_test();
    wr(3'd0, 2);
    wr(3'd1, 0);
    push_frames(2, 0, 0);
    start();
    wait_idle();
    rd_chk(3'd1, 0, "t4_words");
    rd_chk(3'd3, 24, "t4_bytes");
    end_test(2);

    begin_test();
    wr(3'd0, 4);
    wr(3'd1, 8);
    push_frames(4, 8, 0);
    start();
    wait_sop(2);
    start();
    wait_idle();
    rd_chk(3'd2, 4, "t5_pkts");
    rd_chk(3'd3, 272, "t5_bytes");
    end_test(4);

    begin_test();
    wr(3'd0, 0);
    wr(3'd1, 4);
    wr(3'd5, 7);
    push_frames(1, 4, 0);
    start();
    wait_sop(1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("rst_mid_tx", {bus.tx_valid, bus.tx_sop, bus.tx_eop}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    begin_test();
    rd_chk(3'd0, 0, "rst2_num");
    rd_chk(3'd1, 8, "rst2_words");
    rd_chk(3'd5, 2, "rst2_gap");
    rd_chk(3'd2, 0, "rst2_pkts");
    rd_chk(3'd7, 0, "rst2_ctrl");

    begin_test();
    push_frames(1, 8, 0);
    wr(3'd7, 32'h3);
    wr(3'd7, 32'h0);
    wait_idle();
    rd_chk(3'd2, 1, "t6_pkts");
    rd_chk(3'd7, 0, "t6_ctrl");
    end_test(1);

    begin_test();
    wr(3'd0, 2);
    push_frames(2, 8, 0);
    start();
    rd_chk(3'd2, 0, "t7_pkts_clr");
    rd_chk(3'd3, 0, "t7_bytes_clr");
    wait_idle();
    rd_chk(3'd2, 2, "t7_pkts");
    rd_chk(3'd3, 136, "t7_bytes");
    end_test(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_10g_gen.md
Name: eth_10g_gen

Overview:
- 10G Ethernet packet generator for the reference-design loopback path. It produces Avalon-ST 64-bit frames with an appended Ethernet CRC-32, and those frames are consumed downstream by the packet monitor.
- Software programs it through an 8-word Avalon-MM register file and starts or stops it there. It reports packets and bytes sent.

Parameters:
- DEFAULT_WORDS, 8, reset value of the payload length register, in 64-bit words.
- DEFAULT_GAP, 2, reset value of the inter-packet idle-cycle register.

Ports:
- clk  in  1  register and Avalon-ST clock.
- reset_n  in  1  reset, asynchronous and active-low.
- address  in  3  register address.
- write  in  1  register write strobe.
- read  in  1  register read strobe.
- writedata  in  32  register write data.
- readdata  out  32  register read data; combinational; 0 when read=0.
- tx_data  out  64  Avalon-ST data; first byte is in [63:56].
- tx_valid  out  1  Avalon-ST valid.
- tx_sop  out  1  start of packet.
- tx_eop  out  1  end of packet.
- tx_empty  out  3  empty bytes on the EOP beat.
- tx_error  out  1  always 0.
- tx_ready  in  1  Avalon-ST ready; readyLatency 0.

Behaviour:
- Registers:
  - 0 number_packet: R/W, reset 0. Value 0 means continuous generation.
  - 1 pkt_words: R/W [10:0], reset DEFAULT_WORDS. Value 0 is treated as 1.
  - 2 packets_sent: RO.
  - 3/4 byte_sent: RO, [31:0]/[63:32].
  - 5 gap_cycles: R/W [7:0], reset DEFAULT_GAP.
  - 6: reads 0.
  - 7 ctrl_status: bit0 start (W), bit1 stop (W), bit2 done (RO), bit3 busy (RO).
- Start is the rising edge of ctrl_status[0], edge-detected with a one-flop delay.
  - Start clears packets_sent, byte_sent and done.
  - Start is ignored while busy.
- Reset: all outputs are 0. tx_valid=0, FSM=IDLE, all counters 0.
- FSM:
  - IDLE: on start, latch pkt_words, gap_cycles and number_packet into shadow regs, then go to DATA with word index k=0.
  - DATA: tx_valid=1. tx_data = {seq[31:0], k[31:0]}, where seq = packets_sent value at SOP. tx_sop=1 when k=0.
    - A beat advances only when tx_valid & tx_ready. Outputs hold stable while tx_ready=0.
    - After beat k = words-1 transfers, go to CRC.
  - CRC: one beat, tx_data = {fcs[31:0], 32'h0}, tx_eop=1, tx_empty=4.
    - fcs is in transmit byte order: fcs byte0 goes in [63:56].
    - On transfer: packets_sent+1, byte_sent += 8*words+4. Then go to GAP, or to IDLE if finishing.
  - GAP: tx_valid=0 for gap_cycles cycles (0 means back-to-back), then back to DATA.
- Finishing is triggered when:
  - the number_packet shadow is nonzero and packets_sent reaches it, which sets done; or
  - stop has been seen.
- Stop: write of bit1 sets a pending-stop flag. The current packet always completes (it is never truncated), then the FSM returns to IDLE. The flag clears when IDLE is entered.
- CRC: IEEE 802.3, polynomial 0x04C11DB7.
  - Init 0xFFFFFFFF, LSB-first per byte, final complement.
  - Covers payload bytes only, which is exactly the span the downstream crcchk checks.
  - Running CRC updates on each transferred DATA beat. The CRC beat uses the registered result.
- busy = FSM not IDLE.
- Counters wrap modulo 2^32 / 2^64 with no saturation.
- Simultaneous start and stop write in one cycle: stop wins. Generation starts and ends after one packet.
- Writes to shadowed registers while busy take effect at the next start.
- An asynchronous reset mid-packet drops tx_valid immediately. No EOP is emitted.

Decomposition:
- Package eth_10g_pkg holds:
  - register address constants;
  - ctrl bit indices;
  - CRC32_POLY and CRC32_INIT;
  - FSM state encoding (IDLE, DATA, CRC, GAP).
- Sub-module crc32_d64: combinational next-CRC over a 64-bit big-endian-byte word. The generator registers its output.

Test Plan:
- number_packet=3, pkt_words=8, gap=2, tx_ready=1, start → expected response:
  - 3 frames of 9 beats each, with 2 idle cycles between frames;
  - packets_sent=3, byte_sent=204, done=1, busy=0;
  - loopback monitor reports packet_rx_ok=3 and packet_rx_error=0.
- Random tx_ready with 50% duty, number_packet=5, pkt_words=1 → each frame is 2 beats, and data is held stable during stalls. Every fcs matches the bench reference model. byte_sent=60.
- number_packet=0, start, stop written mid-packet 3 → packet 3 completes with eop, then busy=0, packets_sent=3, done=0.
- pkt_words=0 → treated as 1: 2-beat frames with tx_empty=4 on the eop beat.
- Start written again while busy → ignored, counters not cleared. reset_n low mid-frame → tx_valid=0 and all registers return to defaults.
- Same-cycle start+stop → exactly 1 packet sent, then IDLE. Repeating start → counters clear to 0 before counting resumes.
